exec_pipe_stage: RTL and testbench
==================================

EXEC_PIPE_STAGE -- requirements
Module: exec_pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath, PC and result width in bits (legal 8..64).
REQ-002 SHALL have parameter RA_W, default 3: register-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port flush  input  1  synchronous kill of the held and in-flight instruction.
REQ-006 SHALL have port inValid  input  1  upstream instruction valid.
REQ-007 SHALL have port inReady  output  1  stage can accept an instruction this cycle.
REQ-008 SHALL have port op  input  4  ALU opcode; encoding is defined in the package.
REQ-009 SHALL have port brType  input  3  branch condition: NOBR, EQZ, NEZ, LTZ, GEZ.
REQ-010 SHALL have ports srcA, srcB, imm  input  WIDTH each  operands; imm arrives already extended.
REQ-011 SHALL have port useImm  input  1  selects imm instead of srcB as operand B.
REQ-012 SHALL have ports pc, offset  input  WIDTH each  next PC and extended branch/jump offset.
REQ-013 SHALL have port useRegBase  input  1  selects srcA instead of pc as the jump base.
REQ-014 SHALL have ports writeReg (input, RA_W) and regWrt (input, 1)  destination register and write enable.
REQ-015 SHALL have ports outValid (output, 1) and outReady (input, 1)  downstream handshake.
REQ-016 SHALL have ports result and jumpPc (output, WIDTH each), doBranch (output, 1), writeRegOut (output, RA_W), regWrtOut (output, 1), err (output, 1) and busy (output, 1).

Function
REQ-017 SHALL compute inReady = (state==IDLE) & (~outValid | outReady) & ~flush; accept = inValid & inReady.
REQ-018 SHALL register every output of a single-cycle op on the accept edge, giving outValid=1 the next cycle (latency 1).
REQ-019 SHALL hold all outputs stable while outValid & ~outReady.
REQ-020 SHALL clear outValid on a cycle with outReady=1 and no new accept or completion.
REQ-021 SHALL provide ops ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, ROL, SEQ, SLT, SLE, SCO, PASSB, MUL.
REQ-022 SHALL wrap all arithmetic modulo 2^WIDTH; shift amount = operand B[log2(WIDTH)-1:0].
REQ-023 SHALL make SEQ/SLT/SLE (signed, A-B) and SCO (carry out of A+B) produce result 1 or 0.
REQ-024 SHALL compute jumpPc = (useRegBase ? srcA : pc) + offset, modulo 2^WIDTH.
REQ-025 SHALL evaluate doBranch on srcA: EQZ A==0; NEZ A!=0; LTZ A[WIDTH-1]; GEZ ~A[WIDTH-1]; NOBR 0.
REQ-026 SHALL, for an undefined op or brType, set err=1, result=0, regWrtOut=0 and doBranch=0 for that instruction only.
REQ-027 SHALL implement MUL as an FSM IDLE->MUL->IDLE: radix-2 shift-add for exactly WIDTH cycles after accept, with busy=1 and inReady=0 throughout.
REQ-028 SHALL load the low WIDTH bits of the MUL product into result with outValid=1 on the final MUL cycle (latency WIDTH).
REQ-029 SHALL, on flush: clear outValid, doBranch and err, abort MUL to IDLE and drop any same-cycle accept (flush wins).
REQ-030 SHALL, when outValid & outReady coincide with accept, replace the output with the new instruction (no bubble).

Reset
REQ-031 SHALL, on rst low, asynchronously force state=IDLE and zero outValid, result, jumpPc, doBranch, writeRegOut, regWrtOut, err, busy and the multiplier registers.
REQ-032 SHALL make inReady 1 in the first cycle after rst deasserts.

Configuration
REQ-033 SHALL compile the MUL datapath and MUL FSM state only when EXEC_MUL_EN is defined; without it, MUL is an undefined op (REQ-026) with latency 1 and busy tied to 0.

Structure
REQ-034 SHALL keep the opcode and brType localparams, the FSM state encoding and the default WIDTH in the shared package exec_pkg.
REQ-035 SHALL implement the iterative multiplier as sub-module exec_mul_iter (start, operands in; done, product out); other logic stays inline.

Verification
REQ-036 SHALL test ADD: A=16'h7FFF, B=1, outReady=1 -> result=16'h8000, outValid=1 exactly one cycle after accept.
REQ-037 SHALL test MUL with EXEC_MUL_EN and WIDTH=16: A=3, B=16'h5555 -> busy and ~inReady for 16 cycles, then result=16'hFFFF.
REQ-038 SHALL test backpressure: outReady=0 for 3 cycles after the SLT result (A=-2, B=1) -> result=1 held; no accept.
REQ-039 SHALL test flush on MUL cycle 5 -> outValid stays 0, state=IDLE and inReady=1 next cycle.
REQ-040 SHALL test branch GEZ with srcA=0, useRegBase=0, pc=16'h0010, offset=16'hFFFC -> doBranch=1, jumpPc=16'h000C.
REQ-041 SHALL test op=MUL without EXEC_MUL_EN -> err=1, regWrtOut=0, result=0; err=0 on the following ADD.

Source files
------------

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - opcode/branch encodings, FSM state type and default widths for the execute stage
package exec_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_RA_W  = 3;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_ROL   = 4'd8;
    localparam logic [3:0] OP_SEQ   = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_SLE   = 4'd11;
    localparam logic [3:0] OP_SCO   = 4'd12;
    localparam logic [3:0] OP_PASSB = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;

    localparam logic [2:0] BR_NOBR = 3'd0;
    localparam logic [2:0] BR_EQZ  = 3'd1;
    localparam logic [2:0] BR_NEZ  = 3'd2;
    localparam logic [2:0] BR_LTZ  = 3'd3;
    localparam logic [2:0] BR_GEZ  = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } stateT;
endpackage

// File: rtl/exec_pipe_stage_if.sv
// rtl/exec_pipe_stage_if.sv - instruction-in / result-out handshake bundle of the execute stage
interface exec_pipe_stage_if
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RA_W  = DEF_RA_W
);
    logic             inValid;
    logic             inReady;
    logic [3:0]       op;
    logic [2:0]       brType;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [WIDTH-1:0] imm;
    logic             useImm;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] offset;
    logic             useRegBase;
    logic [RA_W-1:0]  writeReg;
    logic             regWrt;

    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] jumpPc;
    logic             doBranch;
    logic [RA_W-1:0]  writeRegOut;
    logic             regWrtOut;
    logic             err;
    logic             busy;

    modport master (
        output inValid, op, brType, srcA, srcB, imm, useImm, pc, offset, useRegBase,
               writeReg, regWrt, outReady,
        input  inReady, outValid, result, jumpPc, doBranch, writeRegOut, regWrtOut, err, busy
    );

    modport slave (
        input  inValid, op, brType, srcA, srcB, imm, useImm, pc, offset, useRegBase,
               writeReg, regWrt, outReady,
        output inReady, outValid, result, jumpPc, doBranch, writeRegOut, regWrtOut, err, busy
    );
endinterface

// File: rtl/exec_mul_iter.sv
// rtl/exec_mul_iter.sv - radix-2 shift-add multiplier, WIDTH steps, low WIDTH product bits
module exec_mul_iter
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             active;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] stepSum;

    // The last partial product is added combinationally so the caller can
    // capture the product on the final step's edge.
    assign stepSum = acc + (mplier[0] ? mcand : '0);
    assign done    = active & (count == CNT_W'(WIDTH - 1));
    assign product = stepSum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            count  <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (active) begin
            acc    <= stepSum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/exec_pipe_stage.sv
// rtl/exec_pipe_stage.sv - single-issue ALU/branch execute stage; iterative MUL built only with EXEC_MUL_EN
module exec_pipe_stage
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RA_W  = DEF_RA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    exec_pipe_stage_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [WIDTH:0]     sum;
    logic [SH_W-1:0]    shamt;
    logic [2*WIDTH-1:0] rolTmp;
    logic [WIDTH-1:0]   aluRes;
    logic [WIDTH-1:0]   jumpTgt;
    logic               aluOk;
    logic               brOk;
    logic               brTaken;
    logic               instErr;
    logic               accept;
    logic               idle;
    logic               startsMul;
    logic               mulDone;
    logic [WIDTH-1:0]   mulProduct;

    logic               outValid;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   jumpPc;
    logic               doBranch;
    logic [RA_W-1:0]    writeRegOut;
    logic               regWrtOut;
    logic               err;

    assign opA     = bus.srcA;
    assign opB     = bus.useImm ? bus.imm : bus.srcB;
    assign shamt   = opB[SH_W-1:0];
    assign sum     = {1'b0, opA} + {1'b0, opB};
    assign rolTmp  = {opA, opA} << shamt;
    assign jumpTgt = (bus.useRegBase ? opA : bus.pc) + bus.offset;

    always_comb begin
        aluRes = '0;
        aluOk  = 1'b1;
        case (bus.op)
            OP_ADD:   aluRes = sum[WIDTH-1:0];
            OP_SUB:   aluRes = opA - opB;
            OP_AND:   aluRes = opA & opB;
            OP_OR:    aluRes = opA | opB;
            OP_XOR:   aluRes = opA ^ opB;
            OP_SLL:   aluRes = opA << shamt;
            OP_SRL:   aluRes = opA >> shamt;
            OP_SRA:   aluRes = $signed(opA) >>> shamt;
            OP_ROL:   aluRes = rolTmp[2*WIDTH-1:WIDTH];
            OP_SEQ:   aluRes = {{(WIDTH-1){1'b0}}, opA == opB};
            OP_SLT:   aluRes = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
            OP_SLE:   aluRes = {{(WIDTH-1){1'b0}}, $signed(opA) <= $signed(opB)};
            OP_SCO:   aluRes = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            OP_PASSB: aluRes = opB;
`ifdef EXEC_MUL_EN
            OP_MUL:   aluRes = '0;
`endif
            default:  aluOk = 1'b0;
        endcase
    end

    always_comb begin
        brTaken = 1'b0;
        brOk    = 1'b1;
        case (bus.brType)
            BR_NOBR: brTaken = 1'b0;
            BR_EQZ:  brTaken = (opA == '0);
            BR_NEZ:  brTaken = (opA != '0);
            BR_LTZ:  brTaken = opA[WIDTH-1];
            BR_GEZ:  brTaken = ~opA[WIDTH-1];
            default: brOk = 1'b0;
        endcase
    end

    assign instErr     = ~aluOk | ~brOk;
    assign bus.inReady = idle & (~outValid | bus.outReady) & ~flush;
    assign accept      = bus.inValid & bus.inReady;

`ifdef EXEC_MUL_EN
    stateT state;
    stateT stateNxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE: if (startsMul) stateNxt = ST_MUL;
            ST_MUL:  if (flush || mulDone) stateNxt = ST_IDLE;
            default: stateNxt = ST_IDLE;
        endcase
    end

    assign idle      = (state == ST_IDLE);
    assign startsMul = accept & (bus.op == OP_MUL) & ~instErr;
    assign bus.busy  = (state == ST_MUL);

    exec_mul_iter #(.WIDTH(WIDTH)) uMul (
        .clk     (clk),
        .rst     (rst),
        .start   (startsMul),
        .abort   (flush),
        .a       (opA),
        .b       (opB),
        .done    (mulDone),
        .product (mulProduct)
    );
`else
    assign idle       = 1'b1;
    assign startsMul  = 1'b0;
    assign mulDone    = 1'b0;
    assign mulProduct = '0;
    assign bus.busy   = 1'b0;
`endif

    // A MUL captures its side-band fields at accept; only result and
    // outValid are written when the product is ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outValid    <= 1'b0;
            result      <= '0;
            jumpPc      <= '0;
            doBranch    <= 1'b0;
            writeRegOut <= '0;
            regWrtOut   <= 1'b0;
            err         <= 1'b0;
        end else if (flush) begin
            outValid <= 1'b0;
            doBranch <= 1'b0;
            err      <= 1'b0;
        end else if (mulDone) begin
            outValid <= 1'b1;
            result   <= mulProduct;
        end else if (accept) begin
            outValid    <= ~startsMul;
            result      <= instErr ? '0 : aluRes;
            jumpPc      <= jumpTgt;
            doBranch    <= brTaken & ~instErr;
            writeRegOut <= bus.writeReg;
            regWrtOut   <= bus.regWrt & ~instErr;
            err         <= instErr;
        end else if (bus.outReady) begin
            outValid <= 1'b0;
        end
    end

    assign bus.outValid    = outValid;
    assign bus.result      = result;
    assign bus.jumpPc      = jumpPc;
    assign bus.doBranch    = doBranch;
    assign bus.writeRegOut = writeRegOut;
    assign bus.regWrtOut   = regWrtOut;
    assign bus.err         = err;
endmodule

// File: tb/tb_exec_pipe_stage.sv
// tb/tb_exec_pipe_stage.sv - randomized bench with a behavioural reference of exec_pipe_stage
module tb_exec_pipe_stage;
    import exec_pkg::*;

    localparam int WIDTH = 16;
    localparam int RA_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic checkEn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    exec_pipe_stage_if #(.WIDTH(WIDTH), .RA_W(RA_W)) bus ();

    exec_pipe_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkW(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] refAlu(input logic [3:0] o, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b, output bit ok);
        longint ua, ub, sa, sb, r;
        int s;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= (64'd1 << (WIDTH - 1))) ? ua - (64'd1 << WIDTH) : ua;
        sb = (ub >= (64'd1 << (WIDTH - 1))) ? ub - (64'd1 << WIDTH) : ub;
        s  = int'(ub % WIDTH);
        ok = 1'b1;
        r  = 0;
        case (o)
            OP_ADD:   r = ua + ub;
            OP_SUB:   r = ua - ub;
            OP_AND:   r = ua & ub;
            OP_OR:    r = ua | ub;
            OP_XOR:   r = ua ^ ub;
            OP_SLL:   r = ua << s;
            OP_SRL:   r = ua >> s;
            OP_SRA:   r = sa >>> s;
            OP_ROL:   r = (s == 0) ? ua : ((ua << s) | (ua >> (WIDTH - s)));
            OP_SEQ:   r = (sa == sb) ? 64'd1 : 64'd0;
            OP_SLT:   r = (sa < sb) ? 64'd1 : 64'd0;
            OP_SLE:   r = (sa <= sb) ? 64'd1 : 64'd0;
            OP_SCO:   r = (ua + ub) >> WIDTH;
            OP_PASSB: r = ub;
`ifdef EXEC_MUL_EN
            OP_MUL:   r = ua * ub;
`endif
            default:  ok = 1'b0;
        endcase
        return WIDTH'(r);
    endfunction

    function automatic logic refBr(input logic [2:0] bt, input logic [WIDTH-1:0] a, output bit ok);
        ok = 1'b1;
        case (bt)
            BR_NOBR: return 1'b0;
            BR_EQZ:  return a == 0;
            BR_NEZ:  return a != 0;
            BR_LTZ:  return $signed(a) < 0;
            BR_GEZ:  return $signed(a) >= 0;
            default: begin ok = 1'b0; return 1'b0; end
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Reference: one output slot plus a count of multiply cycles still owed.
    logic             mValid, mBr, mErr, mWrt;
    logic [WIDTH-1:0] mResult, mJump, mProd;
    logic [RA_W-1:0]  mWr;
    int               mLeft;

    always @(posedge clk or negedge rst) begin
        logic [WIDTH-1:0] b, r;
        logic br, acc;
        bit aok, bok;
        if (!rst) begin
            mValid = 1'b0; mBr = 1'b0; mErr = 1'b0; mWrt = 1'b0;
            mResult = '0; mJump = '0; mProd = '0; mWr = '0; mLeft = 0;
        end else begin
            b   = bus.useImm ? bus.imm : bus.srcB;
            acc = bus.inValid && mLeft == 0 && (!mValid || bus.outReady) && !flush;
            if (flush) begin
                mValid = 1'b0; mBr = 1'b0; mErr = 1'b0; mLeft = 0;
            end else if (mLeft > 0) begin
                mLeft--;
                if (mLeft == 0) begin
                    mValid = 1'b1;
                    mResult = mProd;
                end
            end else if (acc) begin
                r  = refAlu(bus.op, bus.srcA, b, aok);
                br = refBr(bus.brType, bus.srcA, bok);
                mJump = (bus.useRegBase ? bus.srcA : bus.pc) + bus.offset;
                mWr   = bus.writeReg;
                mErr  = !(aok && bok);
                mResult = mErr ? '0 : r;
                mBr   = mErr ? 1'b0 : br;
                mWrt  = mErr ? 1'b0 : bus.regWrt;
                if (bus.op == OP_MUL && !mErr) begin
                    mLeft = WIDTH; mProd = r; mValid = 1'b0;
                end else begin
                    mValid = 1'b1;
                end
            end else if (bus.outReady) begin
                mValid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            chk1("m_inReady", bus.inReady, (mLeft == 0) && (!mValid || bus.outReady) && !flush);
            chk1("m_busy", bus.busy, mLeft != 0);
            chk1("m_outValid", bus.outValid, mValid);
            if (mValid) begin
                chkW("m_result", bus.result, mResult);
                chkW("m_jumpPc", bus.jumpPc, mJump);
                chk1("m_doBranch", bus.doBranch, mBr);
                chk1("m_err", bus.err, mErr);
                chk1("m_regWrtOut", bus.regWrtOut, mWrt);
                vectors++;
                if (bus.writeRegOut !== mWr) begin
                    miscompares++;
                    $display("FAIL m_writeRegOut: got %0d expected %0d", bus.writeRegOut, mWr);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [3:0] o, input logic [2:0] bt, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
        bus.inValid = 1'b1; bus.op = o; bus.brType = bt; bus.srcA = a; bus.srcB = b;
        bus.useImm = 1'b0; bus.imm = '0; bus.pc = 16'h0100; bus.offset = 16'h0004;
        bus.useRegBase = 1'b0; bus.writeReg = 3'd5; bus.regWrt = 1'b1;
    endtask

    initial begin
        drv(OP_ADD, BR_NOBR, '0, '0);
        bus.inValid = 1'b0;
        bus.outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk1("rst_inReady", bus.inReady, 1'b1);
        chk1("rst_outValid", bus.outValid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chkW("rst_result", bus.result, '0);
        chkW("rst_jumpPc", bus.jumpPc, '0);
        chk1("rst_err", bus.err, 1'b0);
        checkEn = 1'b1;

        cyc(); drv(OP_ADD, BR_NOBR, 16'h7FFF, 16'h0001);
        @(negedge clk); chk1("add_pre_valid", bus.outValid, 1'b0);
        cyc(); bus.inValid = 1'b0;
        @(negedge clk);
        chk1("add_valid", bus.outValid, 1'b1);
        chkW("add_result", bus.result, 16'h8000);

        cyc(); drv(OP_ADD, BR_GEZ, 16'h0000, 16'h0000); bus.pc = 16'h0010; bus.offset = 16'hFFFC;
        cyc(); bus.inValid = 1'b0;
        @(negedge clk);
        chk1("gez_doBranch", bus.doBranch, 1'b1);
        chkW("gez_jumpPc", bus.jumpPc, 16'h000C);

        cyc(); drv(OP_SLT, BR_NOBR, 16'hFFFE, 16'h0001);
        cyc(); bus.outReady = 1'b0; drv(OP_ADD, BR_NOBR, 16'h0005, 16'h0005);
        repeat (3) begin
            @(negedge clk);
            chk1("bp_valid", bus.outValid, 1'b1);
            chkW("bp_result", bus.result, 16'h0001);
            chk1("bp_inReady", bus.inReady, 1'b0);
            cyc();
        end
        bus.outReady = 1'b1;
        cyc(); bus.inValid = 1'b0;
        @(negedge clk);
        chkW("bp_replace", bus.result, 16'h000A);

`ifdef EXEC_MUL_EN
        cyc(); drv(OP_MUL, BR_NOBR, 16'h0003, 16'h5555);
        cyc(); bus.inValid = 1'b0;
        repeat (WIDTH) begin
            @(negedge clk);
            chk1("mul_busy", bus.busy, 1'b1);
            chk1("mul_inReady", bus.inReady, 1'b0);
            cyc();
        end
        @(negedge clk);
        chk1("mul_valid", bus.outValid, 1'b1);
        chkW("mul_result", bus.result, 16'hFFFF);

        cyc(); drv(OP_MUL, BR_NOBR, 16'h0003, 16'h0005);
        cyc(); bus.inValid = 1'b0;
        repeat (3) cyc();
        flush = 1'b1;
        cyc(); flush = 1'b0;
        @(negedge clk);
        chk1("mflush_valid", bus.outValid, 1'b0);
        chk1("mflush_busy", bus.busy, 1'b0);
        chk1("mflush_inReady", bus.inReady, 1'b1);
        repeat (WIDTH) begin
            cyc();
            @(negedge clk);
            chk1("mflush_stay", bus.outValid, 1'b0);
        end
`else
        cyc(); drv(OP_MUL, BR_NOBR, 16'h0003, 16'h5555);
        cyc(); drv(OP_ADD, BR_NOBR, 16'h0001, 16'h0002);
        @(negedge clk);
        chk1("nomul_valid", bus.outValid, 1'b1);
        chk1("nomul_err", bus.err, 1'b1);
        chk1("nomul_regWrt", bus.regWrtOut, 1'b0);
        chkW("nomul_result", bus.result, '0);
        chk1("nomul_busy", bus.busy, 1'b0);
        cyc(); bus.inValid = 1'b0;
        @(negedge clk);
        chk1("nomul_next_err", bus.err, 1'b0);
        chkW("nomul_next_result", bus.result, 16'h0003);
`endif

        cyc(); drv(OP_ADD, 3'd6, 16'h0000, 16'h0001); bus.outReady = 1'b0;
        cyc(); bus.inValid = 1'b0;
        @(negedge clk);
        chk1("badbr_err", bus.err, 1'b1);
        chk1("badbr_doBranch", bus.doBranch, 1'b0);
        chkW("badbr_result", bus.result, '0);
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0; bus.outReady = 1'b1;
        @(negedge clk);
        chk1("flush_valid", bus.outValid, 1'b0);
        chk1("flush_err", bus.err, 1'b0);

        repeat (3000) begin
            cyc();
            bus.inValid    = ($urandom_range(0, 9) < 7);
            bus.op         = 4'($urandom);
            bus.brType     = 3'($urandom);
            bus.srcA       = pick();
            bus.srcB       = pick();
            bus.imm        = pick();
            bus.useImm     = 1'($urandom);
            bus.pc         = pick();
            bus.offset     = pick();
            bus.useRegBase = 1'($urandom);
            bus.writeReg   = 3'($urandom);
            bus.regWrt     = 1'($urandom);
            bus.outReady   = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 19) == 0);
        end
        cyc();
        bus.inValid = 1'b0; flush = 1'b0; bus.outReady = 1'b1;
        repeat (WIDTH + 4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
